// File: rtl/stepper_pkg.sv
// Shared stepper definitions: speed codes, coil table, direction.
// Used by the speed selector and by step_drive_gen.
package stepper_pkg;

   localparam logic [2:0] SPD_STOP = 3'd0;
   localparam logic [2:0] SPD_10   = 3'd1;
   localparam logic [2:0] SPD_20   = 3'd2;
   localparam logic [2:0] SPD_30   = 3'd3;
   localparam logic [2:0] SPD_40   = 3'd4;
   localparam logic [2:0] SPD_50   = 3'd5;
   localparam logic [2:0] SPD_60   = 3'd6;
   localparam logic [2:0] SPD_HALT = 3'd7;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   // Entry 0 sits in the low nibble.
   localparam logic [7:0][3:0] COIL_SEQ = {
      4'b1001, 4'b0001, 4'b0011, 4'b0010,
      4'b0110, 4'b0100, 4'b1100, 4'b1000
   };

   function automatic logic spd_ok(input logic [2:0] s);
      return (s != SPD_STOP) && (s != SPD_HALT);
   endfunction

endpackage

// File: rtl/speed_sync.sv
// Three-flop resynchroniser for the speed code; a code is adopted
// only after it has been seen unchanged on two consecutive clocks.
module speed_sync
   import stepper_pkg::*;
(
   input  logic       clk,
   input  logic       resetb,
   input  logic [2:0] spd_in,
   output logic [2:0] spd_out
);

   logic [2:0] s1_q, s2_q, s3_q, spd_q;
   logic [2:0] s1_d, s2_d, s3_d, spd_d;

   always_comb begin
      s1_d  = spd_in;
      s2_d  = s1_q;
      s3_d  = s2_q;
      spd_d = (s2_q == s3_q) ? s2_q : spd_q;
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         s1_q  <= SPD_10;
         s2_q  <= SPD_10;
         s3_q  <= SPD_10;
         spd_q <= SPD_10;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         s3_q  <= s3_d;
         spd_q <= spd_d;
      end
   end

   assign spd_out = spd_q;

endmodule

// File: rtl/step_drive_gen.sv
// Stepper drive: phase accumulator sets the step rate from the
// synchronised speed code, then sequences and decodes the coils.
module step_drive_gen
   import stepper_pkg::*;
#(
   parameter int ACC_W     = 8,
   parameter int THRESH    = 12,
   parameter bit HALF_STEP = 1'b1,
   parameter bit HOLD_EN   = 1'b0
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic [2:0] curr_speed,
   input  logic       enable,
   input  logic       dir,
   output logic       step_tick,
   output logic [2:0] phase_idx,
   output logic [3:0] coils,
   output logic       speed_valid
);

   localparam logic [ACC_W:0] THR      = (ACC_W + 1)'(THRESH);
   localparam logic [2:0]     IDX_STEP = HALF_STEP ? 3'd1 : 3'd2;
   localparam logic [2:0]     IDX_RST  = HALF_STEP ? 3'd0 : 3'd1;

   logic [2:0]       spd;
   logic             run;
   logic [ACC_W:0]   sum;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             tick_q, tick_d;
   logic [2:0]       idx_q, idx_d;
   logic [3:0]       coils_q, coils_d;

   speed_sync u_sync (
      .clk     (clk),
      .resetb  (resetb),
      .spd_in  (curr_speed),
      .spd_out (spd)
   );

   always_comb begin
      run    = enable && spd_ok(spd);
      sum    = {1'b0, acc_q} + (ACC_W + 1)'(spd);
      acc_d  = acc_q;
      tick_d = 1'b0;
      idx_d  = idx_q;
      if (!run) begin
         acc_d = '0;
      end else if (sum >= THR) begin
         // Keep the remainder so the long-run rate is exact.
         acc_d  = ACC_W'(sum - THR);
         tick_d = 1'b1;
         idx_d  = (dir == DIR_REV) ? idx_q - IDX_STEP
                                   : idx_q + IDX_STEP;
      end else begin
         acc_d = sum[ACC_W-1:0];
      end
      coils_d = (enable || HOLD_EN) ? COIL_SEQ[idx_d] : 4'b0000;
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         acc_q   <= '0;
         tick_q  <= 1'b0;
         idx_q   <= IDX_RST;
         coils_q <= 4'b0000;
      end else begin
         acc_q   <= acc_d;
         tick_q  <= tick_d;
         idx_q   <= idx_d;
         coils_q <= coils_d;
      end
   end

   assign step_tick   = tick_q;
   assign phase_idx   = idx_q;
   assign coils       = coils_q;
   assign speed_valid = spd_ok(spd);

endmodule

// File: tb/tb_step_drive_gen.sv
// Scoreboard bench: driver steps a reference model per clock edge,
// monitor compares two DUT configurations on the falling edge.
module tb_step_drive_gen;

   localparam int THRESH = 12;

   logic       clk = 1'b0;
   logic       resetb = 1'b0;
   logic [2:0] curr_speed = 3'd1;
   logic       enable = 1'b0;
   logic       dir = 1'b0;

   logic       tick_h, tick_f, val_h, val_f;
   logic [2:0] idx_h, idx_f;
   logic [3:0] coil_h, coil_f;

   always #5 clk = ~clk;

   step_drive_gen u_half (
      .clk(clk), .resetb(resetb), .curr_speed(curr_speed),
      .enable(enable), .dir(dir), .step_tick(tick_h),
      .phase_idx(idx_h), .coils(coil_h), .speed_valid(val_h)
   );

   step_drive_gen #(.HALF_STEP(1'b0), .HOLD_EN(1'b1)) u_full (
      .clk(clk), .resetb(resetb), .curr_speed(curr_speed),
      .enable(enable), .dir(dir), .step_tick(tick_f),
      .phase_idx(idx_f), .coils(coil_f), .speed_valid(val_f)
   );

   typedef struct {
      int        cyc;
      bit        tick;
      bit        valid;
      bit [2:0]  idx_h;
      bit [3:0]  coil_h;
      bit [2:0]  idx_f;
      bit [3:0]  coil_f;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cycle = 0;

   bit [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                         4'b0010, 4'b0011, 4'b0001, 4'b1001};

   // Reference model state
   int samp[$];
   int m_spd, m_acc, m_tick;
   int m_idx_h, m_idx_f;
   bit [3:0] m_coil_h, m_coil_f;

   function automatic void model_reset();
      samp = '{1, 1, 1};
      m_spd = 1; m_acc = 0; m_tick = 0;
      m_idx_h = 0; m_idx_f = 1;
      m_coil_h = 4'b0000; m_coil_f = 4'b0000;
   endfunction

   function automatic void model_edge();
      exp_t e;
      int   nspd;
      bit   run;
      if (!resetb) begin
         model_reset();
      end else begin
         // samp holds the three most recent samples, newest first
         nspd = (samp[1] == samp[2]) ? samp[1] : m_spd;
         run = enable && m_spd >= 1 && m_spd <= 6;
         m_tick = 0;
         if (!run) begin
            m_acc = 0;
         end else begin
            m_acc += m_spd;
            if (m_acc >= THRESH) begin
               m_acc -= THRESH;
               m_tick = 1;
               m_idx_h = (m_idx_h + (dir ? 7 : 1)) % 8;
               m_idx_f = (m_idx_f + (dir ? 6 : 2)) % 8;
            end
         end
         m_coil_h = enable ? tbl[m_idx_h] : 4'b0000;
         m_coil_f = tbl[m_idx_f];
         samp.push_front(int'(curr_speed));
         void'(samp.pop_back());
         m_spd = nspd;
      end
      e.cyc = cycle;
      e.tick = bit'(m_tick);
      e.valid = (m_spd >= 1 && m_spd <= 6);
      e.idx_h = 3'(m_idx_h);
      e.coil_h = m_coil_h;
      e.idx_f = 3'(m_idx_f);
      e.coil_f = m_coil_f;
      sb.push_back(e);
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         cycle++;
         model_edge();
         #1;
      end
   endtask

   task automatic glitch_cycle(input logic [2:0] g);
      logic [2:0] hold;
      cyc(1);
      hold = curr_speed;
      curr_speed = g;
      #2 curr_speed = hold;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         vectors++;
         if ({tick_h, val_h, idx_h, coil_h} !==
             {e.tick, e.valid, e.idx_h, e.coil_h}) begin
            miscompares++;
            $display("FAIL half cyc %0d: got t=%b v=%b i=%0d c=%b exp t=%b v=%b i=%0d c=%b",
                     e.cyc, tick_h, val_h, idx_h, coil_h,
                     e.tick, e.valid, e.idx_h, e.coil_h);
         end
         vectors++;
         if ({tick_f, val_f, idx_f, coil_f} !==
             {e.tick, e.valid, e.idx_f, e.coil_f}) begin
            miscompares++;
            $display("FAIL full cyc %0d: got t=%b v=%b i=%0d c=%b exp t=%b v=%b i=%0d c=%b",
                     e.cyc, tick_f, val_f, idx_f, coil_f,
                     e.tick, e.valid, e.idx_f, e.coil_f);
         end
      end
   end

   initial begin
      int n;
      model_reset();
      cyc(3);
      resetb = 1'b1;
      enable = 1'b1;
      cyc(40);
      curr_speed = 3'd6;
      cyc(20);
      curr_speed = 3'd5;
      cyc(40);
      curr_speed = 3'd1;
      cyc(15);
      repeat (12) glitch_cycle(3'd6);
      curr_speed = 3'd4;
      cyc(20);
      dir = 1'b1;
      cyc(30);
      dir = 1'b0;
      cyc(9);
      dir = 1'b1;
      cyc(9);
      enable = 1'b0;
      cyc(20);
      enable = 1'b1;
      cyc(15);
      curr_speed = 3'd0;
      cyc(15);
      curr_speed = 3'd7;
      cyc(10);
      curr_speed = 3'd2;
      cyc(10);
      for (int s = 0; s < 40; s++) begin
         curr_speed = 3'($urandom_range(0, 7));
         dir = 1'($urandom_range(0, 1));
         enable = ($urandom_range(0, 7) != 0);
         n = $urandom_range(3, 25);
         for (int c = 0; c < n; c++) begin
            if ($urandom_range(0, 3) == 0)
               glitch_cycle(3'($urandom));
            else
               cyc(1);
         end
      end
      // Asynchronous reset in the middle of a step interval
      curr_speed = 3'd1;
      dir = 1'b0;
      enable = 1'b1;
      cyc(17);
      @(negedge clk);
      #1 resetb = 1'b0;
      #1;
      vectors++;
      if ({tick_h, idx_h, coil_h, tick_f, idx_f, coil_f, val_h} !==
          {1'b0, 3'd0, 4'd0, 1'b0, 3'd1, 4'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL async_reset: got %b/%0d/%b %b/%0d/%b v=%b exp 0/0/0000 0/1/0000 v=1",
                  tick_h, idx_h, coil_h, tick_f, idx_f, coil_f, val_h);
      end
      cyc(3);
      resetb = 1'b1;
      cyc(30);
      enable = 1'b0;
      cyc(3);
      for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, exp 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
